// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : state encoding and requester IDs for mem_arbiter   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_arb_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_IC_BUSY = 3'd1;
    localparam logic [2:0] ST_DC_BUSY = 3'd2;
    localparam logic [2:0] ST_IC_DONE = 3'd3;
    localparam logic [2:0] ST_DC_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        IC_BUSY = ST_IC_BUSY,
        DC_BUSY = ST_DC_BUSY,
        IC_DONE = ST_IC_DONE,
        DC_DONE = ST_DC_DONE
    } arb_state_e;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_if : cache petition and memory port bundle           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int ADDR_WIDTH       = 16
);
    logic                        icPetition;
    logic [ADDR_WIDTH-1:0]       icAddr;
    logic                        icServiceReady;
    logic                        dcPetition;
    logic [ADDR_WIDTH-1:0]       dcAddr;
    logic                        dcWrite;
    logic [CACHE_LINE_WIDTH-1:0] dcWriteData;
    logic                        dcServiceReady;
    logic [CACHE_LINE_WIDTH-1:0] lineOut;
    logic                        memReq;
    logic                        memWe;
    logic [ADDR_WIDTH-1:0]       memAddr;
    logic [CACHE_LINE_WIDTH-1:0] memWriteData;
    logic [CACHE_LINE_WIDTH-1:0] memDataRead;

    // Arbiter side
    modport slave (
        input  icPetition, icAddr, dcPetition, dcAddr, dcWrite, dcWriteData, memDataRead,
        output icServiceReady, dcServiceReady, lineOut, memReq, memWe, memAddr, memWriteData
    );

    // Caches and memory side
    modport master (
        output icPetition, icAddr, dcPetition, dcAddr, dcWrite, dcWriteData, memDataRead,
        input  icServiceReady, dcServiceReady, lineOut, memReq, memWe, memAddr, memWriteData
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_latency_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | latency_counter : loadable down-counter with zero flag           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_register.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_register : enabled register, cleared by async reset      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arb_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : icache/dcache arbiter for one line-wide memory port|
// | Option ARB_ROUND_ROBIN_EN: alternate grants on ties. Rev 1.0     |
// +------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int ADDR_WIDTH       = 16,
    parameter int MEM_LATENCY      = 5
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus_io
);
    localparam int                   CNT_WIDTH = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(MEM_LATENCY - 1);

    arb_state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic                        we_q, we_d;
    logic                        grant;
    logic                        grant_dc;
    logic                        busy;
    logic                        cnt_zero;
    logic                        capture;
    logic [CACHE_LINE_WIDTH-1:0] wdata_d, wdata_q, line_q;

    assign grant = (state_q == IDLE) && (bus_io.icPetition || bus_io.dcPetition);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_dc = bus_io.dcPetition;
        if (bus_io.dcPetition && bus_io.icPetition) begin
            grant_dc = (last_grant_q == REQ_IC);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_IC;
        end else if (grant) begin
            last_grant_q <= grant_dc ? REQ_DC : REQ_IC;
        end
    end
`else
    // dcache holds the older instruction, so it always wins.
    assign grant_dc = bus_io.dcPetition;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = grant_dc ? DC_BUSY : IC_BUSY;
                    addr_d  = grant_dc ? bus_io.dcAddr : bus_io.icAddr;
                    we_d    = grant_dc & bus_io.dcWrite;
                end
            end
            IC_BUSY: if (cnt_zero) state_d = IC_DONE;
            DC_BUSY: if (cnt_zero) state_d = DC_DONE;
            IC_DONE: state_d = IDLE;
            DC_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

    assign busy    = (state_q == IC_BUSY) || (state_q == DC_BUSY);
    assign capture = busy && cnt_zero && !we_q;
    assign wdata_d = grant_dc ? bus_io.dcWriteData : '0;

    latency_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_latency_counter (
        .clk          (clk),
        .reset        (reset),
        .load_i       (grant),
        .load_value_i (CNT_LOAD),
        .dec_i        (busy),
        .zero_o       (cnt_zero)
    );

    mem_arb_register #(
        .WIDTH (CACHE_LINE_WIDTH)
    ) u_wdata_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (grant),
        .d_i   (wdata_d),
        .q_o   (wdata_q)
    );

    mem_arb_register #(
        .WIDTH (CACHE_LINE_WIDTH)
    ) u_line_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (capture),
        .d_i   (bus_io.memDataRead),
        .q_o   (line_q)
    );

    assign bus_io.memReq         = busy;
    assign bus_io.memWe          = busy & we_q;
    assign bus_io.memAddr        = addr_q;
    assign bus_io.memWriteData   = wdata_q;
    assign bus_io.lineOut        = line_q;
    assign bus_io.icServiceReady = (state_q == IC_DONE);
    assign bus_io.dcServiceReady = (state_q == DC_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench, main instance latency 5 plus  |
// | a latency-1 instance. Rev 1.0                                    |
// +------------------------------------------------------------------+
module tb_mem_arbiter;
    localparam int LAT = 5;

    logic clk;
    logic reset;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic         is_dc;
        logic [255:0] line;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    mem_arbiter_if #(.CACHE_LINE_WIDTH(256), .ADDR_WIDTH(16)) ifc ();
    mem_arbiter_if #(.CACHE_LINE_WIDTH(256), .ADDR_WIDTH(16)) ifc1 ();

    mem_arbiter #(.CACHE_LINE_WIDTH(256), .ADDR_WIDTH(16), .MEM_LATENCY(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (ifc.slave)
    );

    mem_arbiter #(.CACHE_LINE_WIDTH(256), .ADDR_WIDTH(16), .MEM_LATENCY(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (ifc1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ifc.icServiceReady || ifc.dcServiceReady) begin
            check("single_ready", ifc.icServiceReady & ifc.dcServiceReady, 1'b0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready @cyc %0d: got ic=%0b dc=%0b, expected no pulse",
                         cyc, ifc.icServiceReady, ifc.dcServiceReady);
            end else begin
                mon_e = sb_q.pop_front();
                check("ready_requester", ifc.dcServiceReady, mon_e.is_dc);
                check("ready_cycle", cyc, mon_e.cyc);
                check("lineOut", ifc.lineOut, mon_e.line);
            end
        end
    end

    task automatic xfer(input logic is_dc, input logic wr, input logic [15:0] addr,
                        input logic [255:0] wdata, input logic [255:0] rdata,
                        input logic [255:0] line_exp, input int drop_k);
        exp_t e;
        int   t0;
        t0 = cyc;
        if (is_dc) begin
            ifc.dcPetition  = 1'b1;
            ifc.dcAddr      = addr;
            ifc.dcWrite     = wr;
            ifc.dcWriteData = wdata;
        end else begin
            ifc.icPetition = 1'b1;
            ifc.icAddr     = addr;
        end
        ifc.memDataRead = rdata;
        e.is_dc = is_dc;
        e.line  = line_exp;
        e.cyc   = t0 + LAT + 1;
        sb_q.push_back(e);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == drop_k) begin
                ifc.icPetition = 1'b0;
                ifc.dcPetition = 1'b0;
            end
            check("busy_memReq", ifc.memReq, 1'b1);
            check("busy_memAddr", ifc.memAddr, addr);
            check("busy_memWe", ifc.memWe, wr);
            if (wr) check("busy_memWriteData", ifc.memWriteData, wdata);
        end
        for (int k = LAT + 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            check("post_memReq", ifc.memReq, 1'b0);
            check("post_memWe", ifc.memWe, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   t0;
        logic [255:0] pat_a5, pat_dead, pat_3c, pat_5a, pat_x1, pat_x2, pat_y, pat_z, pat_96;
        pat_a5   = {32{8'hA5}};
        pat_dead = {16{16'hDEAD}};
        pat_3c   = {32{8'h3C}};
        pat_5a   = {32{8'h5A}};
        pat_x1   = {8{32'h1234_5678}};
        pat_x2   = {8{32'h8765_4321}};
        pat_y    = {4{64'h0123_4567_89AB_CDEF}};
        pat_z    = {16{16'hBEEF}};
        pat_96   = {32{8'h96}};

        reset = 1'b1;
        ifc.icPetition = 1'b0;  ifc.icAddr = '0;
        ifc.dcPetition = 1'b0;  ifc.dcAddr = '0;  ifc.dcWrite = 1'b0;
        ifc.dcWriteData = '0;   ifc.memDataRead = '0;
        ifc1.icPetition = 1'b0; ifc1.icAddr = '0;
        ifc1.dcPetition = 1'b0; ifc1.dcAddr = '0; ifc1.dcWrite = 1'b0;
        ifc1.dcWriteData = '0;  ifc1.memDataRead = '0;

        repeat (2) @(negedge clk);
        check("rst_memReq", ifc.memReq, 1'b0);
        check("rst_memWe", ifc.memWe, 1'b0);
        check("rst_icReady", ifc.icServiceReady, 1'b0);
        check("rst_dcReady", ifc.dcServiceReady, 1'b0);
        check("rst_lineOut", ifc.lineOut, '0);
        check("rst_memAddr", ifc.memAddr, '0);
        check("rst_memWriteData", ifc.memWriteData, '0);
        reset = 1'b0;

        // icache read, then dcache write-back (lineOut must keep A5), then dcache read
        xfer(1'b0, 1'b0, 16'h0040, '0, pat_a5, pat_a5, 1);
        xfer(1'b1, 1'b1, 16'h2000, pat_dead, pat_3c, pat_a5, 1);
        xfer(1'b1, 1'b0, 16'h1111, '0, pat_5a, pat_5a, 2);

        // Simultaneous petitions: dcache first, icache granted at edge 7
        t0 = cyc;
        ifc.dcPetition = 1'b1; ifc.dcAddr = 16'h1230; ifc.dcWrite = 1'b0;
        ifc.icPetition = 1'b1; ifc.icAddr = 16'h0080;
        ifc.memDataRead = pat_x1;
        e.is_dc = 1'b1; e.line = pat_x1; e.cyc = t0 + 6;  sb_q.push_back(e);
        e.is_dc = 1'b0; e.line = pat_x2; e.cyc = t0 + 13; sb_q.push_back(e);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 6) begin
                ifc.dcPetition = 1'b0;
                ifc.memDataRead = pat_x2;
            end
            if (k == 8) ifc.icPetition = 1'b0;
            if (k <= 5) begin
                check("tie_dc_memReq", ifc.memReq, 1'b1);
                check("tie_dc_memAddr", ifc.memAddr, 16'h1230);
            end else if (k >= 8 && k <= 12) begin
                check("tie_ic_memReq", ifc.memReq, 1'b1);
                check("tie_ic_memAddr", ifc.memAddr, 16'h0080);
            end else begin
                check("tie_gap_memReq", ifc.memReq, 1'b0);
            end
        end

        // Petition dropped in cycle 3: transfer still completes
        xfer(1'b0, 1'b0, 16'h0300, '0, pat_y, pat_y, 3);

        // Asynchronous reset in mid-cycle 3 aborts the transfer silently
        ifc.icPetition = 1'b1; ifc.icAddr = 16'h0100; ifc.memDataRead = pat_z;
        repeat (3) @(negedge clk);
        check("pre_rst_memReq", ifc.memReq, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_memReq", ifc.memReq, 1'b0);
        check("async_rst_lineOut", ifc.lineOut, '0);
        check("async_rst_memAddr", ifc.memAddr, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        xfer(1'b0, 1'b0, 16'h0100, '0, pat_z, pat_z, 1);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        // Latency 1: held icache petition served every 3 cycles
        ifc1.icPetition = 1'b1; ifc1.icAddr = 16'h0ABC; ifc1.memDataRead = pat_96;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 9) ifc1.icPetition = 1'b0;
            check("lat1_memReq", ifc1.memReq, (k % 3) == 1);
            check("lat1_icReady", ifc1.icServiceReady, (k % 3) == 2);
            check("lat1_dcReady", ifc1.dcServiceReady, 1'b0);
            if (k == 2) check("lat1_lineOut", ifc1.lineOut, pat_96);
        end
        repeat (2) @(negedge clk);
        check("lat1_idle_memReq", ifc1.memReq, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
